ren_conv_wb_slave: RTL and testbench
====================================

Name: ren_conv_wb_slave

Overview:
- Wishbone classic slave front end for one convolver instance.
- Decodes the bus into three things: a control/status register file, image and kernel memory write ports, and a result memory read port.
- Exposes the decoded configuration fields to the convolver core and generates ack with the correct read latency.
- One copy per instance; instances are selected by the address top byte.

Parameters:
- INST_ID, 0, instance number; the block responds when adr[31:24] == 8'h30 + INST_ID.
- IMG_ADDR_WIDTH, 6, image memory word-address width.
- KERN_ADDR_WIDTH, 6, kernel memory word-address width.
- RSLT_ADDR_WIDTH, 6, result memory word-address width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; writes apply only when all four are set.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- img_we_o  out  1  image write strobe.
- img_addr_o  out  IMG_ADDR_WIDTH  image word address.
- img_wdata_o  out  24  image word.
- kern_we_o  out  1  kernel write strobe.
- kern_addr_o  out  KERN_ADDR_WIDTH  kernel word address.
- kern_wdata_o  out  24  kernel word.
- res_addr_o  out  RSLT_ADDR_WIDTH  result read address.
- res_rdata_i  in  8  result data, valid 1 cycle after res_addr_o.
- core_done_i  in  1  one-cycle pulse when the core finishes.
- start_o, soft_rst_o  out  1 each  control bits.
- kern_cols_o 3, cols_o 8, kerns_o 3, stride_o 8, result_cols_o 8, shift_o 4, kern_addr_mode_o 1, en_max_pool_o 1, mask_o 3  out  configuration fields.

Behaviour:
- Address decode:
  - hit = cyc & stb & (adr[31:24] == 8'h30 + INST_ID).
  - Region = adr[9:8]: 0 regs, 1 image, 2 kernel, 3 result.
  - Word index = adr[7:2].
  - Only hits are acked; non-hits leave ack low (another instance responds).
- Register map:
  - REG0: bit0 done (RO, sticky), bit1 soft_rst, bit2 start.
  - REG1: [2:0] kern_cols, [15:8] cols, [18:16] kerns, [31:24] stride.
  - REG2: [7:0] result_cols, [11:8] shift, [16] kern_addr_mode, [17] en_max_pool, [20:18] mask.
  - Unused bits read 0. Register indices 3..63 read 0; writes to them are ignored but still acked.
- Image/kernel regions:
  - Writes drive we for exactly one cycle with wdata = dat_i[23:0].
  - Reads return 0 (write-only).
- Result region:
  - Reads return {24'd0, res_rdata_i}.
  - Writes are ignored but acked.
- FSM states:
  - IDLE: on hit & we, perform the write side effect, go to ACK. On hit & ~we to the result region, drive res_addr_o, go to RD_WAIT. On any other read hit, latch the data, go to ACK.
  - RD_WAIT: latch res_rdata_i into dat_o, go to ACK.
  - ACK: ack_o=1 for one cycle, go to DONE_WAIT.
  - DONE_WAIT: return to IDLE once stb or cyc is low. This prevents a double ack on a held strobe.
- Latency (ack high at edge N after the request is sampled at edge 0):
  - Writes and register reads: N=1.
  - Result reads: N=2.
- dat_o holds its value until the next read completes.
- done bit:
  - Set on core_done_i.
  - Cleared by a REG0 write with start rising 0->1, or with soft_rst=1.
  - If core_done_i coincides with a clearing write, set wins.
- start_o and soft_rst_o are level outputs equal to the REG0 bits.
- Reset: all outputs and registers 0, FSM IDLE. A reset mid-transaction drops ack immediately, and no write strobe is issued.
- soft_rst_o is only a bit for the core; it does not reset this block's registers.

Decomposition:
- Package ren_conv_pkg holds:
  - region codes (REG/IMG/KERN/RES), register indices 0..2;
  - field bit positions and widths for REG0..REG2;
  - BASE_HI = 8'h30.
- Natural sub-module: ren_conv_regfile (REG0..REG2 storage, done sticky logic, field breakout). The FSM and decode stay in the top.

Test Plan:
- Write 0x0000_0002 then 0x0103_0807 to adr 0x3000_0004 -> kern_cols_o=7, cols_o=8, kerns_o=3, stride_o=1, ack exactly 1 cycle, 1 cycle after the request; read back returns 0x0103_0807.
- Write 0x0302_0100 to 0x3000_0108 -> img_we_o one-cycle pulse, img_addr_o=2, img_wdata_o=0x020100; read of the same address returns 0.
- Result read at 0x3000_030C with res_rdata_i=0x5A (1-cycle memory model) -> res_addr_o=3, ack at edge 2, dat_o=0x0000_005A.
- Write 4 to REG0, pulse core_done_i, read REG0 -> 0x5. Write 0, then 4 again -> read 0x4. Pulse done in the same cycle as the start write -> done reads 1.
- INST_ID=1: access 0x3000_0004 -> no ack, no state change. Access 0x3100_0004 -> acked. Read 0x3100_0020 -> 0, acked.
- Assert wb_rst_i while in RD_WAIT -> ack_o, dat_o and all fields 0 asynchronously. The next transaction completes normally. Holding stb after ack yields no second ack.

Source files
------------

// File: rtl/ren_conv_pkg.sv
// Shared constants for the convolver Wishbone front end: region codes,
// register indices and the bit layout of the three control/status registers.
package ren_conv_pkg;

   localparam logic [7:0] BASE_HI = 8'h30;

   typedef enum logic [1:0] {
      RGN_REG  = 2'd0,
      RGN_IMG  = 2'd1,
      RGN_KERN = 2'd2,
      RGN_RES  = 2'd3
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_ACK,
      ST_DONE_WAIT
   } wb_state_e;

   localparam logic [5:0] REG_CTRL = 6'd0;
   localparam logic [5:0] REG_GEOM = 6'd1;
   localparam logic [5:0] REG_MISC = 6'd2;

   // REG0
   localparam int CTRL_DONE_BIT  = 0;
   localparam int CTRL_SRST_BIT  = 1;
   localparam int CTRL_START_BIT = 2;

   // REG1
   localparam int KCOLS_LSB  = 0;
   localparam int KCOLS_W    = 3;
   localparam int COLS_LSB   = 8;
   localparam int COLS_W     = 8;
   localparam int KERNS_LSB  = 16;
   localparam int KERNS_W    = 3;
   localparam int STRIDE_LSB = 24;
   localparam int STRIDE_W   = 8;

   // REG2
   localparam int RCOLS_LSB  = 0;
   localparam int RCOLS_W    = 8;
   localparam int SHIFT_LSB  = 8;
   localparam int SHIFT_W    = 4;
   localparam int KMODE_BIT  = 16;
   localparam int MPOOL_BIT  = 17;
   localparam int MASK_LSB   = 18;
   localparam int MASK_W     = 3;

endpackage

// File: rtl/ren_conv_regfile.sv
// Control/status register storage for one convolver instance: sticky done
// flag, start/soft-reset level bits and the decoded geometry fields.
module ren_conv_regfile
   import ren_conv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_en_i,
   input  logic [5:0]  wr_idx_i,
   input  logic [31:0] wr_data_i,
   input  logic [5:0]  rd_idx_i,
   output logic [31:0] rd_data_o,
   input  logic        core_done_i,
   output logic        start_o,
   output logic        soft_rst_o,
   output logic [2:0]  kern_cols_o,
   output logic [7:0]  cols_o,
   output logic [2:0]  kerns_o,
   output logic [7:0]  stride_o,
   output logic [7:0]  result_cols_o,
   output logic [3:0]  shift_o,
   output logic        kern_addr_mode_o,
   output logic        en_max_pool_o,
   output logic [2:0]  mask_o
);

   logic       done_q, done_d;
   logic       start_q, start_d;
   logic       srst_q, srst_d;
   logic [2:0] kern_cols_q, kern_cols_d;
   logic [7:0] cols_q, cols_d;
   logic [2:0] kerns_q, kerns_d;
   logic [7:0] stride_q, stride_d;
   logic [7:0] rcols_q, rcols_d;
   logic [3:0] shift_q, shift_d;
   logic       kmode_q, kmode_d;
   logic       mpool_q, mpool_d;
   logic [2:0] mask_q, mask_d;
   logic       unused_wr;

   assign unused_wr = ^wr_data_i;

   always_comb begin
      done_d      = done_q;
      start_d     = start_q;
      srst_d      = srst_q;
      kern_cols_d = kern_cols_q;
      cols_d      = cols_q;
      kerns_d     = kerns_q;
      stride_d    = stride_q;
      rcols_d     = rcols_q;
      shift_d     = shift_q;
      kmode_d     = kmode_q;
      mpool_d     = mpool_q;
      mask_d      = mask_q;
      if (wr_en_i && wr_idx_i == REG_CTRL) begin
         start_d = wr_data_i[CTRL_START_BIT];
         srst_d  = wr_data_i[CTRL_SRST_BIT];
         if ((wr_data_i[CTRL_START_BIT] && !start_q) || wr_data_i[CTRL_SRST_BIT])
            done_d = 1'b0;
      end
      if (wr_en_i && wr_idx_i == REG_GEOM) begin
         kern_cols_d = wr_data_i[KCOLS_LSB +: KCOLS_W];
         cols_d      = wr_data_i[COLS_LSB +: COLS_W];
         kerns_d     = wr_data_i[KERNS_LSB +: KERNS_W];
         stride_d    = wr_data_i[STRIDE_LSB +: STRIDE_W];
      end
      if (wr_en_i && wr_idx_i == REG_MISC) begin
         rcols_d = wr_data_i[RCOLS_LSB +: RCOLS_W];
         shift_d = wr_data_i[SHIFT_LSB +: SHIFT_W];
         kmode_d = wr_data_i[KMODE_BIT];
         mpool_d = wr_data_i[MPOOL_BIT];
         mask_d  = wr_data_i[MASK_LSB +: MASK_W];
      end
      // A finishing core beats a simultaneous clearing write.
      if (core_done_i)
         done_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_q      <= 1'b0;
         start_q     <= 1'b0;
         srst_q      <= 1'b0;
         kern_cols_q <= '0;
         cols_q      <= '0;
         kerns_q     <= '0;
         stride_q    <= '0;
         rcols_q     <= '0;
         shift_q     <= '0;
         kmode_q     <= 1'b0;
         mpool_q     <= 1'b0;
         mask_q      <= '0;
      end else begin
         done_q      <= done_d;
         start_q     <= start_d;
         srst_q      <= srst_d;
         kern_cols_q <= kern_cols_d;
         cols_q      <= cols_d;
         kerns_q     <= kerns_d;
         stride_q    <= stride_d;
         rcols_q     <= rcols_d;
         shift_q     <= shift_d;
         kmode_q     <= kmode_d;
         mpool_q     <= mpool_d;
         mask_q      <= mask_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      case (rd_idx_i)
         REG_CTRL: begin
            rd_data_o[CTRL_DONE_BIT]  = done_q;
            rd_data_o[CTRL_SRST_BIT]  = srst_q;
            rd_data_o[CTRL_START_BIT] = start_q;
         end
         REG_GEOM: begin
            rd_data_o[KCOLS_LSB +: KCOLS_W]   = kern_cols_q;
            rd_data_o[COLS_LSB +: COLS_W]     = cols_q;
            rd_data_o[KERNS_LSB +: KERNS_W]   = kerns_q;
            rd_data_o[STRIDE_LSB +: STRIDE_W] = stride_q;
         end
         REG_MISC: begin
            rd_data_o[RCOLS_LSB +: RCOLS_W] = rcols_q;
            rd_data_o[SHIFT_LSB +: SHIFT_W] = shift_q;
            rd_data_o[KMODE_BIT]            = kmode_q;
            rd_data_o[MPOOL_BIT]            = mpool_q;
            rd_data_o[MASK_LSB +: MASK_W]   = mask_q;
         end
         default: ;
      endcase
   end

   assign start_o          = start_q;
   assign soft_rst_o       = srst_q;
   assign kern_cols_o      = kern_cols_q;
   assign cols_o           = cols_q;
   assign kerns_o          = kerns_q;
   assign stride_o         = stride_q;
   assign result_cols_o    = rcols_q;
   assign shift_o          = shift_q;
   assign kern_addr_mode_o = kmode_q;
   assign en_max_pool_o    = mpool_q;
   assign mask_o           = mask_q;

endmodule

// File: rtl/ren_conv_wb_slave.sv
// Wishbone classic slave for one convolver: decodes register, image, kernel
// and result regions and sequences ack so every hit is acknowledged exactly once.
module ren_conv_wb_slave
   import ren_conv_pkg::*;
#(
   parameter int INST_ID         = 0,
   parameter int IMG_ADDR_WIDTH  = 6,
   parameter int KERN_ADDR_WIDTH = 6,
   parameter int RSLT_ADDR_WIDTH = 6
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_we_i,
   input  logic [3:0]                 wbs_sel_i,
   input  logic [31:0]                wbs_dat_i,
   input  logic [31:0]                wbs_adr_i,
   output logic                       wbs_ack_o,
   output logic [31:0]                wbs_dat_o,
   output logic                       img_we_o,
   output logic [IMG_ADDR_WIDTH-1:0]  img_addr_o,
   output logic [23:0]                img_wdata_o,
   output logic                       kern_we_o,
   output logic [KERN_ADDR_WIDTH-1:0] kern_addr_o,
   output logic [23:0]                kern_wdata_o,
   output logic [RSLT_ADDR_WIDTH-1:0] res_addr_o,
   input  logic [7:0]                 res_rdata_i,
   input  logic                       core_done_i,
   output logic                       start_o,
   output logic                       soft_rst_o,
   output logic [2:0]                 kern_cols_o,
   output logic [7:0]                 cols_o,
   output logic [2:0]                 kerns_o,
   output logic [7:0]                 stride_o,
   output logic [7:0]                 result_cols_o,
   output logic [3:0]                 shift_o,
   output logic                       kern_addr_mode_o,
   output logic                       en_max_pool_o,
   output logic [2:0]                 mask_o
);

   wb_state_e                  state_q, state_d;
   logic [31:0]                dat_q, dat_d;
   logic                       img_we_q, img_we_d;
   logic [IMG_ADDR_WIDTH-1:0]  img_addr_q, img_addr_d;
   logic [23:0]                img_wdata_q, img_wdata_d;
   logic                       kern_we_q, kern_we_d;
   logic [KERN_ADDR_WIDTH-1:0] kern_addr_q, kern_addr_d;
   logic [23:0]                kern_wdata_q, kern_wdata_d;
   logic [RSLT_ADDR_WIDTH-1:0] res_addr_q, res_addr_d;

   logic        hit;
   logic        full_sel;
   region_e     region;
   logic [5:0]  word_idx;
   logic        reg_wr_en;
   logic [31:0] reg_rd_data;
   logic        unused_adr;

   assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI + 8'(INST_ID));
   assign full_sel = &wbs_sel_i;
   assign region   = region_e'(wbs_adr_i[9:8]);
   assign word_idx = wbs_adr_i[7:2];
   assign unused_adr = ^{wbs_adr_i[23:10], wbs_adr_i[1:0]};

   always_comb begin
      state_d      = state_q;
      dat_d        = dat_q;
      img_we_d     = 1'b0;
      img_addr_d   = img_addr_q;
      img_wdata_d  = img_wdata_q;
      kern_we_d    = 1'b0;
      kern_addr_d  = kern_addr_q;
      kern_wdata_d = kern_wdata_q;
      res_addr_d   = res_addr_q;
      reg_wr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit && wbs_we_i) begin
               state_d = ST_ACK;
               if (full_sel) begin
                  case (region)
                     RGN_REG: reg_wr_en = 1'b1;
                     RGN_IMG: begin
                        img_we_d    = 1'b1;
                        img_addr_d  = IMG_ADDR_WIDTH'(word_idx);
                        img_wdata_d = wbs_dat_i[23:0];
                     end
                     RGN_KERN: begin
                        kern_we_d    = 1'b1;
                        kern_addr_d  = KERN_ADDR_WIDTH'(word_idx);
                        kern_wdata_d = wbs_dat_i[23:0];
                     end
                     default: ;
                  endcase
               end
            end else if (hit && region == RGN_RES) begin
               res_addr_d = RSLT_ADDR_WIDTH'(word_idx);
               state_d    = ST_RD_WAIT;
            end else if (hit) begin
               dat_d   = (region == RGN_REG) ? reg_rd_data : 32'd0;
               state_d = ST_ACK;
            end
         end
         ST_RD_WAIT: begin
            dat_d   = {24'd0, res_rdata_i};
            state_d = ST_ACK;
         end
         ST_ACK:       state_d = ST_DONE_WAIT;
         ST_DONE_WAIT: if (!wbs_stb_i || !wbs_cyc_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         dat_q        <= '0;
         img_we_q     <= 1'b0;
         img_addr_q   <= '0;
         img_wdata_q  <= '0;
         kern_we_q    <= 1'b0;
         kern_addr_q  <= '0;
         kern_wdata_q <= '0;
         res_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         dat_q        <= dat_d;
         img_we_q     <= img_we_d;
         img_addr_q   <= img_addr_d;
         img_wdata_q  <= img_wdata_d;
         kern_we_q    <= kern_we_d;
         kern_addr_q  <= kern_addr_d;
         kern_wdata_q <= kern_wdata_d;
         res_addr_q   <= res_addr_d;
      end
   end

   // The result memory has one cycle of read latency, so the address must be
   // presented combinationally in the request cycle and held through RD_WAIT.
   always_comb begin
      res_addr_o = res_addr_q;
      if (state_q == ST_IDLE && hit && !wbs_we_i && region == RGN_RES)
         res_addr_o = RSLT_ADDR_WIDTH'(word_idx);
      if (wb_rst_i)
         res_addr_o = '0;
   end

   assign wbs_ack_o    = (state_q == ST_ACK);
   assign wbs_dat_o    = dat_q;
   assign img_we_o     = img_we_q;
   assign img_addr_o   = img_addr_q;
   assign img_wdata_o  = img_wdata_q;
   assign kern_we_o    = kern_we_q;
   assign kern_addr_o  = kern_addr_q;
   assign kern_wdata_o = kern_wdata_q;

   ren_conv_regfile u_regfile (
      .clk_i            (wb_clk_i),
      .rst_i            (wb_rst_i),
      .wr_en_i          (reg_wr_en),
      .wr_idx_i         (word_idx),
      .wr_data_i        (wbs_dat_i),
      .rd_idx_i         (word_idx),
      .rd_data_o        (reg_rd_data),
      .core_done_i      (core_done_i),
      .start_o          (start_o),
      .soft_rst_o       (soft_rst_o),
      .kern_cols_o      (kern_cols_o),
      .cols_o           (cols_o),
      .kerns_o          (kerns_o),
      .stride_o         (stride_o),
      .result_cols_o    (result_cols_o),
      .shift_o          (shift_o),
      .kern_addr_mode_o (kern_addr_mode_o),
      .en_max_pool_o    (en_max_pool_o),
      .mask_o           (mask_o)
   );

endmodule

// File: tb/tb_ren_conv_wb_slave.sv
// Two instances (INST_ID 0 and 1) share one Wishbone bus; directed and random
// transactions are checked against a word-level model of the register map.
module tb_ren_conv_wb_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_w = '0, adr = '0;

   logic        ack [2];
   logic [31:0] dat_o [2];
   logic        img_we [2];
   logic [5:0]  img_addr [2];
   logic [23:0] img_wdata [2];
   logic        kern_we [2];
   logic [5:0]  kern_addr [2];
   logic [23:0] kern_wdata [2];
   logic [5:0]  res_addr [2];
   logic [7:0]  res_rdata [2];
   logic        core_done [2];
   logic        start_s [2], srst_s [2];
   logic [2:0]  kern_cols [2], kerns [2], mask [2];
   logic [7:0]  cols [2], stride [2], rcols [2];
   logic [3:0]  shift [2];
   logic        kmode [2], mpool [2];

   logic [7:0]  res_mem [64];
   int          n_checks = 0, n_errors = 0;
   int          ack_cnt [2];
   logic [31:0] mon_img[$], mon_kern[$], exp_img[$], exp_kern[$];

   // word-level model
   logic [31:0] m_reg1 [2], m_reg2 [2], m_last_rd [2];
   logic        m_start [2], m_srst [2], m_done [2];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ren_conv_wb_slave #(.INST_ID(gi)) u_dut (
         .wb_clk_i(clk), .wb_rst_i(rst),
         .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
         .wbs_dat_i(dat_w), .wbs_adr_i(adr),
         .wbs_ack_o(ack[gi]), .wbs_dat_o(dat_o[gi]),
         .img_we_o(img_we[gi]), .img_addr_o(img_addr[gi]), .img_wdata_o(img_wdata[gi]),
         .kern_we_o(kern_we[gi]), .kern_addr_o(kern_addr[gi]), .kern_wdata_o(kern_wdata[gi]),
         .res_addr_o(res_addr[gi]), .res_rdata_i(res_rdata[gi]),
         .core_done_i(core_done[gi]),
         .start_o(start_s[gi]), .soft_rst_o(srst_s[gi]),
         .kern_cols_o(kern_cols[gi]), .cols_o(cols[gi]), .kerns_o(kerns[gi]),
         .stride_o(stride[gi]), .result_cols_o(rcols[gi]), .shift_o(shift[gi]),
         .kern_addr_mode_o(kmode[gi]), .en_max_pool_o(mpool[gi]), .mask_o(mask[gi])
      );
   end

   // 1-cycle result memory and bus-side monitors (sampled at the active edge)
   always @(posedge clk) begin
      res_rdata[0] <= res_mem[res_addr[0]];
      res_rdata[1] <= res_mem[res_addr[1]];
      for (int i = 0; i < 2; i++) if (ack[i]) ack_cnt[i]++;
      if (img_we[0])  mon_img.push_back({2'b00, img_addr[0], img_wdata[0]});
      if (kern_we[0]) mon_kern.push_back({2'b00, kern_addr[0], kern_wdata[0]});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_fields(input int i);
      chk("start",     32'(start_s[i]),   32'(m_start[i]));
      chk("soft_rst",  32'(srst_s[i]),    32'(m_srst[i]));
      chk("kern_cols", 32'(kern_cols[i]), 32'(m_reg1[i][2:0]));
      chk("cols",      32'(cols[i]),      32'(m_reg1[i][15:8]));
      chk("kerns",     32'(kerns[i]),     32'(m_reg1[i][18:16]));
      chk("stride",    32'(stride[i]),    32'(m_reg1[i][31:24]));
      chk("rcols",     32'(rcols[i]),     32'(m_reg2[i][7:0]));
      chk("shift",     32'(shift[i]),     32'(m_reg2[i][11:8]));
      chk("kmode",     32'(kmode[i]),     32'(m_reg2[i][16]));
      chk("mpool",     32'(mpool[i]),     32'(m_reg2[i][17]));
      chk("mask",      32'(mask[i]),      32'(m_reg2[i][20:18]));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_reg1[i] = '0; m_reg2[i] = '0; m_last_rd[i] = '0;
         m_start[i] = 1'b0; m_srst[i] = 1'b0; m_done[i] = 1'b0;
      end
      exp_img.delete(); exp_kern.delete(); mon_img.delete(); mon_kern.delete();
   endtask

   task automatic model_access(input int i, input logic hit, input logic w,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [1:0] rgn;
      logic [5:0] idx;
      rgn = a[9:8];
      idx = a[7:2];
      if (!hit) return;
      if (w) begin
         if (s != 4'hF) return;
         case (rgn)
            2'd0: begin
               if (idx == 0) begin
                  if ((d[2] && !m_start[i]) || d[1]) m_done[i] = 1'b0;
                  m_start[i] = d[2];
                  m_srst[i]  = d[1];
               end else if (idx == 1) m_reg1[i] = d & 32'hFF07_FF07;
               else if (idx == 2)     m_reg2[i] = d & 32'h001F_0FFF;
            end
            2'd1: if (i == 0) exp_img.push_back({2'b00, idx, d[23:0]});
            2'd2: if (i == 0) exp_kern.push_back({2'b00, idx, d[23:0]});
            default: ;
         endcase
      end else begin
         case (rgn)
            2'd0: m_last_rd[i] = (idx == 0) ? {29'd0, m_start[i], m_srst[i], m_done[i]} :
                                 (idx == 1) ? m_reg1[i] : (idx == 2) ? m_reg2[i] : 32'd0;
            2'd3: m_last_rd[i] = {24'd0, res_mem[idx]};
            default: m_last_rd[i] = 32'd0;
         endcase
      end
   endtask

   // One bus cycle; lat = edge count to ack on instance 'inst', 0 if none within budget.
   task automatic bus(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit pulse, input int hold, output int lat);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      core_done[inst] = pulse;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); @(negedge clk);
         core_done[inst] = 1'b0;
         if (ack[inst]) begin lat = k; break; end
      end
      repeat (hold) @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
   endtask

   task automatic op(input int watch, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit pulse, input int hold, input string tag);
      int   exp_lat, lat, c0, c1;
      logic h [2];
      exp_lat = 0;
      for (int i = 0; i < 2; i++) begin
         h[i] = (a[31:24] == 8'h30 + 8'(i));
         if (h[i] && i == watch) exp_lat = (!w && a[9:8] == 2'd3) ? 2 : 1;
         model_access(i, h[i], w, a, d, s);
      end
      c0 = ack_cnt[0]; c1 = ack_cnt[1];
      bus(watch, w, a, d, s, pulse, hold, lat);
      if (pulse) m_done[watch] = 1'b1;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_acks0"}, 32'(ack_cnt[0] - c0), h[0] ? 32'd1 : 32'd0);
      chk({tag, "_acks1"}, 32'(ack_cnt[1] - c1), h[1] ? 32'd1 : 32'd0);
      chk({tag, "_dat0"}, dat_o[0], m_last_rd[0]);
      chk({tag, "_dat1"}, dat_o[1], m_last_rd[1]);
      chk({tag, "_img_n"}, 32'(mon_img.size()), 32'(exp_img.size()));
      chk({tag, "_kern_n"}, 32'(mon_kern.size()), 32'(exp_kern.size()));
      while (mon_img.size() > 0 && exp_img.size() > 0)
         chk({tag, "_img"}, mon_img.pop_front(), exp_img.pop_front());
      while (mon_kern.size() > 0 && exp_kern.size() > 0)
         chk({tag, "_kern"}, mon_kern.pop_front(), exp_kern.pop_front());
      mon_img.delete(); mon_kern.delete(); exp_img.delete(); exp_kern.delete();
      chk_fields(0);
      chk_fields(1);
      $display("op %s: we=%0d adr=%h dat=%h sel=%h lat=%0d dat_o=%h", tag, w, a, d, s, lat, dat_o[watch]);
   endtask

   task automatic pulse_done(input int i);
      @(negedge clk); core_done[i] = 1'b1;
      @(negedge clk); core_done[i] = 1'b0;
      m_done[i] = 1'b1;
   endtask

   initial begin
      logic [1:0]  rgn;
      logic [5:0]  idx;
      logic [7:0]  hi;
      logic [31:0] a, d;
      logic [3:0]  s;
      int          watch;
      core_done[0] = 1'b0; core_done[1] = 1'b0;
      ack_cnt[0] = 0; ack_cnt[1] = 0;
      for (int i = 0; i < 64; i++) res_mem[i] = 8'($urandom);
      res_mem[3] = 8'h5A;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_dat", dat_o[0], 32'd0);
      chk("rst_img_we", 32'(img_we[0]), 32'd0);
      chk_fields(0);
      rst = 1'b0;

      // configuration register write/readback
      op(0, 1'b1, 32'h3000_0004, 32'h0000_0002, 4'hF, 1'b0, 0, "reg1_w0");
      op(0, 1'b1, 32'h3000_0004, 32'h0103_0807, 4'hF, 1'b0, 0, "reg1_w1");
      chk("kern_cols_7", 32'(kern_cols[0]), 32'd7);
      chk("cols_8",      32'(cols[0]),      32'd8);
      chk("kerns_3",     32'(kerns[0]),     32'd3);
      chk("stride_1",    32'(stride[0]),    32'd1);
      op(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, 0, "reg1_r");
      chk("reg1_readback", dat_o[0], 32'h0103_0807);

      // image write, write-only readback
      op(0, 1'b1, 32'h3000_0108, 32'h0302_0100, 4'hF, 1'b0, 0, "img_w");
      op(0, 1'b0, 32'h3000_0108, 32'h0, 4'hF, 1'b0, 0, "img_r");
      chk("img_read_zero", dat_o[0], 32'd0);

      // result read, two-edge latency
      op(0, 1'b0, 32'h3000_030C, 32'h0, 4'hF, 1'b0, 0, "res_r");
      chk("res_addr_3", 32'(res_addr[0]), 32'd3);
      chk("res_data_5a", dat_o[0], 32'h0000_005A);

      // sticky done
      op(0, 1'b1, 32'h3000_0000, 32'h4, 4'hF, 1'b0, 0, "start_w");
      pulse_done(0);
      op(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, "done_r1");
      chk("done_5", dat_o[0], 32'h5);
      op(0, 1'b1, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, "stop_w");
      op(0, 1'b1, 32'h3000_0000, 32'h4, 4'hF, 1'b0, 0, "restart_w");
      op(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, "done_r2");
      chk("done_cleared_4", dat_o[0], 32'h4);
      op(0, 1'b1, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, "stop_w2");
      op(0, 1'b1, 32'h3000_0000, 32'h4, 4'hF, 1'b1, 0, "start_done_w");
      op(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, "done_r3");
      chk("done_set_wins", dat_o[0], 32'h5);

      // instance select
      op(1, 1'b1, 32'h3000_0004, 32'h0505_0505, 4'hF, 1'b0, 0, "inst1_miss");
      op(1, 1'b1, 32'h3100_0004, 32'h0A0B_0C06, 4'hF, 1'b0, 0, "inst1_w");
      op(1, 1'b0, 32'h3100_0020, 32'h0, 4'hF, 1'b0, 0, "inst1_r_unused");
      chk("inst1_unused_zero", dat_o[1], 32'd0);
      op(0, 1'b0, 32'h3200_0004, 32'h0, 4'hF, 1'b0, 0, "nobody");

      // held strobe must not produce a second ack
      op(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, 5, "hold_stb");

      // random traffic
      for (int n = 0; n < 60; n++) begin
         rgn = 2'($urandom_range(0, 3));
         if (rgn == 2'd0 && $urandom_range(0, 3) == 0) idx = 6'($urandom_range(3, 63));
         else if (rgn == 2'd0) idx = 6'($urandom_range(0, 2));
         else idx = 6'($urandom_range(0, 63));
         case ($urandom_range(0, 7))
            0:       begin hi = 8'h31; watch = 1; end
            1:       begin hi = 8'h32; watch = 0; end
            default: begin hi = 8'h30; watch = 0; end
         endcase
         a = {hi, 14'($urandom), rgn, idx, 2'b00};
         d = $urandom;
         s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
         op(watch, 1'($urandom_range(0, 1)), a, d, s, ($urandom_range(0, 7) == 0), 0, "rnd");
      end

      // reset while waiting on result memory
      op(0, 1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, "pre_rst_w");
      op(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, 0, "pre_rst_r");
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0314; sel = 4'hF;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rdwait_rst_ack", 32'(ack[0]), 32'd0);
      chk("rdwait_rst_dat", dat_o[0], 32'd0);
      chk("rdwait_rst_res_addr", 32'(res_addr[0]), 32'd0);
      chk_fields(0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mon_img.delete(); mon_kern.delete();
      op(0, 1'b0, 32'h3000_030C, 32'h0, 4'hF, 1'b0, 0, "post_rst_res_r");
      chk("post_rst_data", dat_o[0], 32'h0000_005A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
